// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
//   PAR_*  : par_mode encodings (even, odd, mark, space)
//   state_t: parity engine FSM states (idle, serial calculation, result held)
package uart_tx_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'd0;
  localparam logic [1:0] PAR_ODD   = 2'd1;
  localparam logic [1:0] PAR_MARK  = 2'd2;
  localparam logic [1:0] PAR_SPACE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_parity_engine.sv
// Serial parity generator for the UART transmit path.
// A character is loaded when data_valid && !busy and the engine is not
// calculating; parity is then accumulated one bit per clock over the
// effective character length and presented as a registered bit.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   data_valid   character present on p_data
//   busy         serializer busy; blocks a load
//   p_data       character, LSB first (DATA_WIDTH bits)
//   data_len     character length in bits (0 / >DATA_WIDTH clamp to DATA_WIDTH)
//   par_en       parity enabled, sampled at load
//   par_mode     0 even, 1 odd, 2 mark, 3 space; sampled at load
//   par_bit      registered parity bit
//   par_ready    par_bit valid for the last loaded character
//   calc_busy    engine is in the serial calculation state
//
// Build option: define PARITY_MARK_SPACE_EN to make par_mode 2/3 produce
// fixed mark/space parity with one-cycle latency. Without it par_mode[1] is
// ignored and modes 2/3 behave as even/odd.
module uart_parity_engine
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  output logic                  par_bit,
  output logic                  par_ready,
  output logic                  calc_busy
);

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   data_q, data_d, mask, shifted;
  logic [LEN_W-1:0]        cnt, cnt_d, len_q, len_d, eff_len;
  logic [1:0]              mode_q, mode_d;
  logic                    en_q, en_d;
  logic                    acc, acc_d, acc_next;
  logic                    bit_d, ready_d;
  logic                    load, bypass, ms_en;

`ifdef PARITY_MARK_SPACE_EN
  assign ms_en = 1'b1;
`else
  assign ms_en = 1'b0;
`endif

  assign load      = data_valid && !busy && (state != ST_CALC);
  assign bypass    = !par_en || (ms_en && par_mode[1]);
  assign eff_len   = (data_len == '0 || data_len > MAX_LEN) ? MAX_LEN : data_len;
  assign shifted   = data_q >> cnt;
  assign acc_next  = acc ^ shifted[0];
  assign calc_busy = (state == ST_CALC);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = (i < 32'(eff_len));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      cnt       <= '0;
      len_q     <= '0;
      en_q      <= 1'b0;
      mode_q    <= PAR_EVEN;
      acc       <= 1'b0;
      par_bit   <= 1'b0;
      par_ready <= 1'b0;
    end else begin
      state     <= state_next;
      data_q    <= data_d;
      cnt       <= cnt_d;
      len_q     <= len_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      acc       <= acc_d;
      par_bit   <= bit_d;
      par_ready <= ready_d;
    end
  end

  always_comb begin
    state_next = state;
    data_d     = data_q;
    cnt_d      = cnt;
    len_d      = len_q;
    en_d       = en_q;
    mode_d     = mode_q;
    acc_d      = acc;
    bit_d      = par_bit;
    ready_d    = par_ready;

    if (load) begin
      data_d     = p_data & mask;
      len_d      = eff_len;
      en_d       = par_en;
      mode_d     = par_mode;
      cnt_d      = '0;
      acc_d      = 1'b0;
      ready_d    = 1'b0;
      state_next = bypass ? ST_DONE : ST_CALC;
    end else begin
      case (state)
        ST_CALC: begin
          acc_d = acc_next;
          cnt_d = cnt + ONE;
          if (cnt == len_q - ONE) begin
            state_next = ST_DONE;
            bit_d      = mode_q[0] ? ~acc_next : acc_next;
            ready_d    = 1'b1;
          end
        end
        ST_DONE: begin
          // A bypass load enters DONE with par_ready low; the fixed result
          // is written on the following edge to give one-cycle latency.
          if (!par_ready) begin
            bit_d   = en_q && (mode_q == PAR_MARK);
            ready_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: directed scenarios followed by
// randomized characters, compared against a popcount-based parity model.
module tb_uart_parity_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          data_valid;
  logic          busy;
  logic [DW-1:0] p_data;
  logic [LW-1:0] data_len;
  logic          par_en;
  logic [1:0]    par_mode;
  logic          par_bit;
  logic          par_ready;
  logic          calc_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_parity_engine #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .busy      (busy),
    .p_data    (p_data),
    .data_len  (data_len),
    .par_en    (par_en),
    .par_mode  (par_mode),
    .par_bit   (par_bit),
    .par_ready (par_ready),
    .calc_busy (calc_busy)
  );

`ifdef PARITY_MARK_SPACE_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  function automatic int unsigned model_len(input logic [LW-1:0] l);
    return (l == 0 || 32'(l) > DW) ? DW : 32'(l);
  endfunction

  function automatic bit model_bypass(input logic en, input logic [1:0] m);
    return !en || (MS && m >= 2'd2);
  endfunction

  function automatic logic model_parity(input logic [DW-1:0] d, input logic [LW-1:0] l,
                                        input logic en, input logic [1:0] m);
    int unsigned ones = 0;
    int unsigned n = model_len(l);
    for (int unsigned i = 0; i < n; i++) ones += 32'(d[i]);
    if (!en) return 1'b0;
    if (MS && m == 2'd2) return 1'b1;
    if (MS && m == 2'd3) return 1'b0;
    return (m[0] ? ((ones + 1) % 2) : (ones % 2)) != 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load one character and follow it through to its result.
  task automatic run_char(input string tag, input logic [DW-1:0] d, input logic [LW-1:0] l,
                          input logic en, input logic [1:0] m);
    int unsigned lat;
    logic exp_bit;
    lat     = model_bypass(en, m) ? 1 : model_len(l);
    exp_bit = model_parity(d, l, en, m);
    @(negedge clk);
    data_valid = 1'b1; busy = 1'b0; p_data = d; data_len = l; par_en = en; par_mode = m;
    @(posedge clk); #1;
    data_valid = 1'b0;
    check($sformatf("%s/ready_clr", tag), 32'(par_ready), 32'd0);
    check($sformatf("%s/busy_t0", tag), 32'(calc_busy), model_bypass(en, m) ? 32'd0 : 32'd1);
    for (int unsigned k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k < lat) begin
        check($sformatf("%s/busy_%0d", tag, k), 32'(calc_busy), 32'd1);
        check($sformatf("%s/nrdy_%0d", tag, k), 32'(par_ready), 32'd0);
      end else begin
        check($sformatf("%s/ready", tag), 32'(par_ready), 32'd1);
        check($sformatf("%s/bit", tag), 32'(par_bit), 32'(exp_bit));
        check($sformatf("%s/idle", tag), 32'(calc_busy), 32'd0);
      end
    end
  endtask

  initial begin
    logic held;
    rst = 1'b1; data_valid = 1'b0; busy = 1'b0; p_data = '0;
    data_len = '0; par_en = 1'b0; par_mode = 2'd0;
    #2;
    check("rst/bit", 32'(par_bit), 32'd0);
    check("rst/ready", 32'(par_ready), 32'd0);
    check("rst/busy", 32'(calc_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Basic even/odd, back-to-back from DONE.
    run_char("a5_even", 8'hA5, 4'd8, 1'b1, 2'd0);
    run_char("a5_odd", 8'hA5, 4'd8, 1'b1, 2'd1);
    // Length masking and clamping.
    run_char("ff_len5", 8'hFF, 4'd5, 1'b1, 2'd0);
    run_char("ff_len0", 8'hFF, 4'd0, 1'b1, 2'd0);
    run_char("ff_len12", 8'h7F, 4'd12, 1'b1, 2'd0);
    run_char("len1", 8'hFF, 4'd1, 1'b1, 2'd1);
    // Mark/space and disabled parity.
    run_char("mark", 8'hA4, 4'd8, 1'b1, 2'd2);
    run_char("space", 8'hA4, 4'd8, 1'b1, 2'd3);
    run_char("noparity", 8'hA4, 4'd8, 1'b0, 2'd1);

    // data_valid during CALC is ignored.
    @(negedge clk);
    data_valid = 1'b1; busy = 1'b0; p_data = 8'h03; data_len = 4'd8; par_en = 1'b1; par_mode = 2'd0;
    @(posedge clk); #1;
    p_data = 8'h01; par_mode = 2'd1;
    repeat (3) @(posedge clk); #1;
    data_valid = 1'b0;
    check("ign_calc/busy", 32'(calc_busy), 32'd1);
    repeat (5) @(posedge clk); #1;
    check("ign_calc/ready", 32'(par_ready), 32'd1);
    check("ign_calc/bit", 32'(par_bit), 32'd0);

    // Load blocked while the serializer is busy.
    held = par_bit;
    @(negedge clk);
    busy = 1'b1; data_valid = 1'b1; p_data = 8'h01; par_mode = 2'd0;
    repeat (3) @(posedge clk); #1;
    check("blocked/ready", 32'(par_ready), 32'd1);
    check("blocked/busy", 32'(calc_busy), 32'd0);
    check("blocked/bit", 32'(par_bit), 32'(held));
    run_char("after_busy", 8'h01, 4'd8, 1'b1, 2'd0);

    // Reset in the middle of a calculation (par_bit is 1 beforehand).
    run_char("pre_rst", 8'hA5, 4'd8, 1'b1, 2'd1);
    @(negedge clk);
    data_valid = 1'b1; busy = 1'b0; p_data = 8'hA5; data_len = 4'd8; par_en = 1'b1; par_mode = 2'd0;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst/bit", 32'(par_bit), 32'd0);
    check("midrst/ready", 32'(par_ready), 32'd0);
    check("midrst/busy", 32'(calc_busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("midrst/lost", 32'(par_ready), 32'd0);
    run_char("post_rst", 8'h01, 4'd8, 1'b1, 2'd1);

    // Randomized characters.
    for (int n = 0; n < 60; n++) begin
      run_char($sformatf("rnd%0d", n), DW'($urandom), LW'($urandom_range(0, 15)),
               ($urandom_range(0, 4) != 0), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

- Parametrised parity generator for the UART transmit path.
- Accepts a character of up to DATA_WIDTH bits from the TX front end when the serializer is idle.
- Computes parity serially, one bit per clock, over a run-time character length, with selectable even/odd (and optionally mark/space) parity.
- Presents a registered parity bit with a ready flag for the serializer's parity slot.

## Interface

Parameters:
- DATA_WIDTH, 8: maximum character width; legal range 5..16.
- LEN_W, $clog2(DATA_WIDTH+1): width of data_len; derived, do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_valid  in  1  character present on p_data.
- busy  in  1  serializer busy; a load is blocked while high.
- p_data  in  DATA_WIDTH  character, LSB first.
- data_len  in  LEN_W  character length in bits.
- par_en  in  1  parity enabled for this character; sampled at load.
- par_mode  in  2  0 even, 1 odd, 2 mark, 3 space; sampled at load.
- par_bit  out  1  registered parity bit.
- par_ready  out  1  par_bit valid for the last loaded character.
- calc_busy  out  1  engine in CALC state.

## Operation

- Load condition: data_valid && !busy && state != CALC. A load in state DONE restarts the engine.
- At the load edge:
  - p_data is captured with bits at index >= effective length forced to 0.
  - par_en, par_mode and the effective length are captured.
  - Bit counter and accumulator are cleared.
  - par_ready is cleared.
- Effective length: data_len if 1 <= data_len <= DATA_WIDTH; otherwise DATA_WIDTH (0 or out-of-range values clamp).
- States:
  - IDLE, on load:
    - if bypass, go to DONE;
    - otherwise go to CALC.
  - CALC: each edge, acc <= acc ^ data_q[cnt] and cnt <= cnt + 1. On the edge that processes bit len-1, go to DONE.
  - DONE:
    - hold par_bit, par_ready = 1;
    - on load, go to CALC (or stay in DONE via bypass).
- Bypass: par_en = 0, or mark/space mode when PARITY_MARK_SPACE_EN is defined.
- par_bit written on entry to DONE:
  - par_en = 0: 0.
  - even: XOR of the masked character.
  - odd: inverted XOR.
  - mark: 1.
  - space: 0.
- data_valid during CALC is ignored; no queueing.
- calc_busy = 1 exactly while state is CALC.

## Timing

- Reset values:
  - par_bit = 0, par_ready = 0, calc_busy = 0.
  - state = IDLE, counter = 0, accumulator = 0, captured data = 0.
- Reset asserted mid-CALC or in DONE: immediate return to reset values; the pending result is lost.
- Load edge T0. Calculated path: calc_busy is high from T0 to T0+len; par_bit and par_ready are updated at edge T0+len. Latency is len cycles (8 for an 8-bit character).
- Bypass path: par_bit and par_ready are updated at edge T0+1.
- par_ready falls at the load edge of the next character and stays low until that result is written.
- Simultaneous load with busy = 1: no load. The state is unchanged and par_ready keeps its old value.

## Configuration

- PARITY_MARK_SPACE_EN defined:
  - par_mode 2 gives mark (par_bit = 1).
  - par_mode 3 gives space (par_bit = 0).
  - Both take the bypass path with 1-cycle latency.
- PARITY_MARK_SPACE_EN undefined:
  - par_mode[1] is ignored; 2 behaves as even and 3 as odd.
  - Both use the full serial calculation.

## Structure

- Shared package uart_tx_pkg holds:
  - par_mode encoding constants: PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE;
  - state encoding: ST_IDLE, ST_CALC, ST_DONE.
- Single module; no sub-module warranted. The counter and accumulator stay inline with the FSM.

## Test plan

- p_data = 8'hA5, data_len = 8, par_en = 1, even -> par_bit = 0, par_ready rises 8 cycles after load, calc_busy high for 8 cycles.
- Same character with odd mode -> par_bit = 1. Back-to-back load from DONE clears par_ready at the load edge.
- p_data = 8'hFF, data_len = 5, even -> masked to 5 ones, par_bit = 1 after 5 cycles. data_len = 0 clamps to 8 -> par_bit = 0.
- par_mode = 2 with macro -> par_bit = 1, par_ready after 1 cycle. Without macro -> even result after len cycles. par_en = 0 -> par_bit = 0 after 1 cycle.
- Two ignored loads, then a normal one:
  - data_valid = 1 with busy = 1 -> no load;
  - a second data_valid mid-CALC -> ignored, result reflects the first character;
  - after busy drops in DONE -> new load accepted.
- rst pulsed at cycle 3 of CALC -> all outputs 0 immediately. A subsequent load of 8'h01 odd -> par_bit = 0 after 8 cycles.
